// File: rtl/ts_pkg.sv
// Shared constants and FSM state encoding for the TS stream arbiter.
package ts_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t FWD  = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_CH.
module rr_priority_picker #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IdxW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic            gnt_valid,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = IdxW'((32'(ptr) + off) % N_CH);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ts_stream_arbiter.sv
// Packet-aware round-robin arbiter: forwards one sync-aligned TS packet per grant from N_CH channels.
module ts_stream_arbiter
  import ts_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PKT_LEN = TS_PKT_LEN,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [8*N_CH-1:0]       ch_byte,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH-1:0]         ch_sync,
  output logic [7:0]              byte_out,
  output logic                    valid_out,
  output logic                    sync_out,
  output logic [$clog2(N_CH)-1:0] grant_ch,
  output logic                    busy,
  output logic                    pkt_done,
  output logic                    err_abort
);

  localparam int unsigned IdxW = $clog2(N_CH);
  localparam int unsigned CntW = $clog2(PKT_LEN + 1);
  localparam int unsigned IdlW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IdlW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            sync_q, sync_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;

  logic [N_CH-1:0] cand;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [7:0]      pick_byte, g_byte;
  logic            g_valid, g_sync;
  logic [IdxW-1:0] ptr_inc;

  assign cand = ch_en & ch_valid & ch_sync;

  rr_priority_picker #(
    .N_CH (N_CH),
    .IdxW (IdxW)
  ) u_picker (
    .req       (cand),
    .ptr       (rr_ptr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign pick_byte = ch_byte[{pick_idx, 3'b000} +: 8];
  assign g_byte    = ch_byte[{grant_q, 3'b000} +: 8];
  assign g_valid   = ch_valid[grant_q];
  assign g_sync    = ch_sync[grant_q];
  assign ptr_inc   = (grant_q == IdxW'(N_CH - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    busy_d     = busy_q;
    byte_d     = 8'h00;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          byte_d     = pick_byte;
          valid_d    = 1'b1;
          sync_d     = 1'b1;
          byte_cnt_d = CntW'(1);
          idle_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = FWD;
        end
      end
      FWD: begin
        if (!g_valid) begin
          // Abort on the TIMEOUT-th consecutive idle cycle of the granted channel.
          if (idle_cnt_q == IdlW'(TIMEOUT - 1)) begin
            abort_d    = 1'b1;
            busy_d     = 1'b0;
            idle_cnt_d = '0;
            rr_ptr_d   = ptr_inc;
            state_d    = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else if (g_sync) begin
          // Early re-sync: truncate the current packet and start a new one on the same channel.
          abort_d    = 1'b1;
          byte_d     = g_byte;
          valid_d    = 1'b1;
          sync_d     = 1'b1;
          byte_cnt_d = CntW'(1);
          idle_cnt_d = '0;
        end else begin
          byte_d     = g_byte;
          valid_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (byte_cnt_q == CntW'(PKT_LEN - 1)) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            rr_ptr_d = ptr_inc;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign sync_out  = sync_q;
  assign grant_ch  = grant_q;
  assign busy      = busy_q;
  assign pkt_done  = done_q;
  assign err_abort = abort_q;

endmodule

// File: tb/tb_ts_stream_arbiter.sv
// Directed bench for ts_stream_arbiter: vector table plus multi-cycle packet scenarios.
module tb_ts_stream_arbiter;

  localparam int NCH  = 4;
  localparam int PLEN = 188;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [31:0] ch_byte = '0;
  logic [3:0]  ch_valid = '0;
  logic [3:0]  ch_sync = '0;
  logic [7:0]  byte_out;
  logic        valid_out, sync_out, busy, pkt_done, err_abort;
  logic [1:0]  grant_ch;

  int n_vec = 0;
  int n_err = 0;
  int pos[NCH];

  ts_stream_arbiter #(
    .N_CH    (NCH),
    .PKT_LEN (PLEN),
    .TIMEOUT (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .ch_byte   (ch_byte),
    .ch_valid  (ch_valid),
    .ch_sync   (ch_sync),
    .byte_out  (byte_out),
    .valid_out (valid_out),
    .sync_out  (sync_out),
    .grant_ch  (grant_ch),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .err_abort (err_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  v;
    logic [3:0]  s;
    logic [31:0] b;
    logic        ev, es, ed, eb, ea;
    logic [1:0]  eg;
    logic [7:0]  ebyte;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [7:0] pat(int c, int p);
    if (p == 1) return 8'h47;
    return 8'((c * 53 + p * 7 + 1) & 255);
  endfunction

  // Packed compare: {valid, sync, done, busy, abort, grant[1:0], byte[7:0]}.
  task automatic chk_out(input string name, input logic ev, input logic es, input logic ed,
                         input logic eb, input logic ea, input logic [1:0] eg,
                         input logic [7:0] ebyte);
    logic [14:0] act, exp;
    act = {valid_out, sync_out, pkt_done, busy, err_abort, grant_ch, byte_out};
    exp = {ev, es, ed, eb, ea, eg, ebyte};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {v,s,d,busy,ab,gnt,byte}=%b_%b_%b_%b_%b_%0d_%h want %b_%b_%b_%b_%b_%0d_%h",
               name, $time, act[14], act[13], act[12], act[11], act[10], act[9:8], act[7:0],
               exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_en = '0; ch_valid = '0; ch_sync = '0; ch_byte = '0;
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cycle(input logic [3:0] en, input logic [3:0] v, input logic [3:0] s,
                       input logic [31:0] b);
    ch_en = en; ch_valid = v; ch_sync = s; ch_byte = b;
    @(posedge clk);
    #1;
  endtask

  // Channels in 'act' emit their next packet byte; sync accompanies byte 1 (0x47).
  task automatic step(input logic [3:0] en, input logic [3:0] act);
    ch_en = en;
    for (int c = 0; c < NCH; c++) begin
      if (act[c]) begin
        ch_valid[c]       = 1'b1;
        ch_sync[c]        = (pos[c] == 0);
        ch_byte[8*c +: 8] = pat(c, pos[c] + 1);
        pos[c]            = (pos[c] + 1) % PLEN;
      end else begin
        ch_valid[c]       = 1'b0;
        ch_sync[c]        = 1'b0;
        ch_byte[8*c +: 8] = 8'h00;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en, valid, sync, bytes -> valid, sync, done, busy, abort, grant, byte
    tbl[0] = '{4'hF, 4'h0, 4'h0, 32'h0000_0000, 0, 0, 0, 0, 0, 2'd0, 8'h00};
    tbl[1] = '{4'hF, 4'hF, 4'h0, 32'h4747_4747, 0, 0, 0, 0, 0, 2'd0, 8'h00};
    tbl[2] = '{4'h0, 4'hF, 4'hF, 32'h4747_4747, 0, 0, 0, 0, 0, 2'd0, 8'h00};
    tbl[3] = '{4'hF, 4'h0, 4'hF, 32'h4747_4747, 0, 0, 0, 0, 0, 2'd0, 8'h00};
    tbl[4] = '{4'hE, 4'hF, 4'hF, 32'h4747_4747, 1, 1, 0, 1, 0, 2'd1, 8'h47};
    tbl[5] = '{4'hF, 4'h1, 4'h1, 32'h0000_0047, 0, 0, 0, 1, 0, 2'd1, 8'h00};
    tbl[6] = '{4'hF, 4'h2, 4'h0, 32'h0000_1100, 1, 0, 0, 1, 0, 2'd1, 8'h11};
    tbl[7] = '{4'hF, 4'hD, 4'h0, 32'hAA00_33BB, 0, 0, 0, 1, 0, 2'd1, 8'h00};
    tbl[8] = '{4'hF, 4'h2, 4'h2, 32'h0000_4700, 1, 1, 0, 1, 1, 2'd1, 8'h47};
    tbl[9] = '{4'hF, 4'h2, 4'h0, 32'h0000_2200, 1, 0, 0, 1, 0, 2'd1, 8'h22};

    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].b);
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ed, tbl[i].eb, tbl[i].ea,
              tbl[i].eg, tbl[i].ebyte);
    end

    // Single channel, three clean packets.
    do_reset();
    for (int k = 0; k < 3 * PLEN; k++) begin
      int p;
      p = k % PLEN + 1;
      step(4'h1, 4'h1);
      chk_out($sformatf("ch0_only k=%0d", k), 1, p == 1, p == PLEN, p != PLEN, 0, 2'd0,
              pat(0, p));
    end

    // All channels aligned: grants rotate 0,1,2,3,0 with no overlap.
    do_reset();
    for (int k = 0; k < 5 * PLEN; k++) begin
      int p, g;
      p = k % PLEN + 1;
      g = (k / PLEN) % 4;
      step(4'hF, 4'hF);
      chk_out($sformatf("rr_all k=%0d", k), 1, p == 1, p == PLEN, p != PLEN, 0, 2'(g),
              pat(g, p));
    end

    // Masked: only ch1 and ch3 eligible, alternating.
    do_reset();
    for (int k = 0; k < 4 * PLEN; k++) begin
      int p, g;
      p = k % PLEN + 1;
      g = ((k / PLEN) % 2 == 1) ? 3 : 1;
      step(4'hA, 4'hF);
      chk_out($sformatf("rr_mask k=%0d", k), 1, p == 1, p == PLEN, p != PLEN, 0, 2'(g),
              pat(g, p));
    end

    // Timeout on ch2 after byte 49; next grant goes to ch3.
    do_reset();
    for (int k = 1; k <= 49; k++) begin
      step(4'hF, 4'h4);
      chk_out($sformatf("to_pre p=%0d", k), 1, k == 1, 0, 1, 0, 2'd2, pat(2, k));
    end
    for (int i = 1; i <= TOUT; i++) begin
      step(4'hF, 4'h0);
      if (i < TOUT) chk_out($sformatf("to_idle i=%0d", i), 0, 0, 0, 1, 0, 2'd2, 8'h00);
      else          chk_out("to_abort", 0, 0, 0, 0, 1, 2'd2, 8'h00);
    end
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    step(4'hF, 4'hF);
    chk_out("to_next_grant", 1, 1, 0, 1, 0, 2'd3, 8'h47);
    step(4'hF, 4'hF);
    chk_out("to_next_byte2", 1, 0, 0, 1, 0, 2'd3, pat(3, 2));

    // Early re-sync on ch1 at byte 100.
    do_reset();
    for (int k = 1; k <= 99; k++) begin
      step(4'hF, 4'h2);
      chk_out($sformatf("rs_pre p=%0d", k), 1, k == 1, 0, 1, 0, 2'd1, pat(1, k));
    end
    pos[1] = 0;
    step(4'hF, 4'h2);
    chk_out("rs_abort", 1, 1, 0, 1, 1, 2'd1, 8'h47);
    for (int p = 2; p <= PLEN; p++) begin
      step(4'hF, 4'h2);
      chk_out($sformatf("rs_post p=%0d", p), 1, 0, p == PLEN, p != PLEN, 0, 2'd1, pat(1, p));
    end

    // Reset mid-packet at byte 90: silent truncation, regrant only on a fresh sync.
    do_reset();
    for (int k = 1; k <= 89; k++) begin
      step(4'h1, 4'h1);
      chk_out($sformatf("rst_pre p=%0d", k), 1, k == 1, 0, 1, 0, 2'd0, pat(0, k));
    end
    rst = 1'b1;
    step(4'h1, 4'h1);
    chk_out("rst_mid", 0, 0, 0, 0, 0, 2'd0, 8'h00);
    rst = 1'b0;
    for (int p = 91; p <= PLEN; p++) begin
      step(4'h1, 4'h1);
      chk_out($sformatf("rst_nosync p=%0d", p), 0, 0, 0, 0, 0, 2'd0, 8'h00);
    end
    step(4'h1, 4'h1);
    chk_out("rst_regrant", 1, 1, 0, 1, 0, 2'd0, 8'h47);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
